// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with standard or first-word-fall-through read, threshold flags,
// occupancy count, overflow/underflow pulses and a synchronous flush.
module sync_fifo_flags #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       flush,
    input  logic                       winc,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       rinc,
    output logic [WIDTH-1:0]           rdata,
    output logic                       wfull,
    output logic                       rempty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     data_cnt,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             wr_acc, rd_acc;

    // Flags come straight from the count register, so they carry no extra latency.
    assign wfull        = (cnt_q == CW'(DEPTH));
    assign rempty       = (cnt_q == '0);
    assign almost_full  = (cnt_q >= CW'(AF_LEVEL));
    assign almost_empty = (cnt_q <= CW'(AE_LEVEL));
    assign data_cnt     = cnt_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    always_comb begin
        wr_acc  = winc && !wfull && !flush;
        rd_acc  = rinc && !rempty && !flush;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        ovf_d   = winc && wfull && !flush;
        unf_d   = rinc && rempty && !flush;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (wr_acc) wptr_d = wptr_q + AW'(1);
            if (rd_acc) rptr_d = rptr_q + AW'(1);
            if (wr_acc && !rd_acc) cnt_d = cnt_q + CW'(1);
            else if (rd_acc && !wr_acc) cnt_d = cnt_q - CW'(1);
            // Registered read data is only loaded in standard mode; it holds across flush.
            if (FWFT == 0 && rd_acc) rdata_d = mem_q[rptr_q];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wptr_q] <= wdata;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata = rempty ? '0 : mem_q[rptr_q];
        end else begin : g_std
            assign rdata = rdata_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: standard and FWFT instances share stimulus and are
// compared against a queue-based reference plus a hand-written vector table.
module tb_sync_fifo_flags;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             flush = 1'b0;
    logic             winc = 1'b0;
    logic             rinc = 1'b0;
    logic [WIDTH-1:0] wdata = '0;

    logic [WIDTH-1:0] s_rdata, f_rdata;
    logic             s_wfull, s_rempty, s_af, s_ae, s_ovf, s_unf;
    logic             f_wfull, f_rempty, f_af, f_ae, f_ovf, f_unf;
    logic [CW-1:0]    s_cnt, f_cnt;

    sync_fifo_flags #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) dut_std (
        .clk(clk), .rstn(rstn), .flush(flush), .winc(winc), .wdata(wdata), .rinc(rinc),
        .rdata(s_rdata), .wfull(s_wfull), .rempty(s_rempty), .almost_full(s_af),
        .almost_empty(s_ae), .data_cnt(s_cnt), .overflow(s_ovf), .underflow(s_unf)
    );

    sync_fifo_flags #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) dut_fwft (
        .clk(clk), .rstn(rstn), .flush(flush), .winc(winc), .wdata(wdata), .rinc(rinc),
        .rdata(f_rdata), .wfull(f_wfull), .rempty(f_rempty), .almost_full(f_af),
        .almost_empty(f_ae), .data_cnt(f_cnt), .overflow(f_ovf), .underflow(f_unf)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: contents as a queue, plus the registered outputs.
    logic [WIDTH-1:0] mq [$];
    logic [WIDTH-1:0] m_rdata = '0;
    logic             m_ovf = 1'b0;
    logic             m_unf = 1'b0;

    typedef struct {
        logic             f, w, r;
        logic [WIDTH-1:0] d;
        int               cnt;
        logic             full, empty, af, ae, ovf, unf;
        logic [WIDTH-1:0] rd;
    } vec_t;

    vec_t tbl [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_rdata = '0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic model_step(input logic f, input logic w, input logic [WIDTH-1:0] d, input logic r);
        bit full, empty;
        full  = (mq.size() == DEPTH);
        empty = (mq.size() == 0);
        if (f) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            m_ovf = w && full;
            m_unf = r && empty;
            if (r && !empty) m_rdata = mq.pop_front();
            if (w && !full) mq.push_back(d);
        end
    endtask

    task automatic check_model();
        int n;
        logic [WIDTH-1:0] head;
        n    = mq.size();
        head = (n == 0) ? '0 : mq[0];
        chk("cnt",        s_cnt,    n);
        chk("fwft_cnt",   f_cnt,    n);
        chk("wfull",      s_wfull,  n == DEPTH);
        chk("rempty",     s_rempty, n == 0);
        chk("fwft_rempty",f_rempty, n == 0);
        chk("afull",      s_af,     n >= AF);
        chk("aempty",     s_ae,     n <= AE);
        chk("ovf",        s_ovf,    m_ovf);
        chk("unf",        s_unf,    m_unf);
        chk("fwft_ovf",   f_ovf,    m_ovf);
        chk("fwft_unf",   f_unf,    m_unf);
        chk("rdata",      s_rdata,  m_rdata);
        chk("fwft_rdata", f_rdata,  head);
    endtask

    // Drive one cycle's inputs, let the edge happen, then check on the falling edge.
    task automatic cycle(input logic f, input logic w, input logic [WIDTH-1:0] d, input logic r);
        flush = f; winc = w; wdata = d; rinc = r;
        @(posedge clk);
        model_step(f, w, d, r);
        @(negedge clk);
        check_model();
    endtask

    function automatic vec_t mk(input logic w, input logic [WIDTH-1:0] d, input logic r,
                                input int cnt, input logic ovf, input logic unf,
                                input logic [WIDTH-1:0] rd);
        vec_t v;
        v.f = 1'b0; v.w = w; v.d = d; v.r = r;
        v.cnt = cnt;
        v.full  = (cnt == DEPTH);
        v.empty = (cnt == 0);
        v.af    = (cnt >= AF);
        v.ae    = (cnt <= AE);
        v.ovf = ovf; v.unf = unf; v.rd = rd;
        return v;
    endfunction

    initial begin
        // Fill 0x01..0x10, overflow once, drain, underflow once.
        for (int i = 0; i < DEPTH; i++) tbl.push_back(mk(1'b1, WIDTH'(i + 1), 1'b0, i + 1, 1'b0, 1'b0, 8'h00));
        tbl.push_back(mk(1'b1, 8'hEE, 1'b0, 16, 1'b1, 1'b0, 8'h00));
        tbl.push_back(mk(1'b0, 8'h00, 1'b0, 16, 1'b0, 1'b0, 8'h00));
        for (int i = 0; i < DEPTH; i++) tbl.push_back(mk(1'b0, 8'h00, 1'b1, 15 - i, 1'b0, 1'b0, WIDTH'(i + 1)));
        tbl.push_back(mk(1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 8'h10));
        tbl.push_back(mk(1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0, 8'h10));

        // Reset state
        model_reset();
        repeat (2) @(negedge clk);
        check_model();
        rstn = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            cycle(tbl[i].f, tbl[i].w, tbl[i].d, tbl[i].r);
            chk("tbl_cnt",    s_cnt,    tbl[i].cnt);
            chk("tbl_wfull",  s_wfull,  tbl[i].full);
            chk("tbl_rempty", s_rempty, tbl[i].empty);
            chk("tbl_afull",  s_af,     tbl[i].af);
            chk("tbl_aempty", s_ae,     tbl[i].ae);
            chk("tbl_ovf",    s_ovf,    tbl[i].ovf);
            chk("tbl_unf",    s_unf,    tbl[i].unf);
            chk("tbl_rdata",  s_rdata,  tbl[i].rd);
        end

        // FWFT: word written into empty FIFO appears right after the write edge
        cycle(1'b0, 1'b1, 8'hA5, 1'b0);
        chk("fwft_show", f_rdata, 8'hA5);
        chk("fwft_nonempty", f_rempty, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        chk("fwft_drained", f_rempty, 1'b1);
        chk("fwft_zero", f_rdata, 8'h00);

        // Count 8 with simultaneous read/write across pointer wrap
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, WIDTH'($urandom), 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b1, WIDTH'($urandom), 1'b1);
            chk("steady_cnt", s_cnt, 8);
        end

        // Full with both requests: only the read is taken
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, WIDTH'($urandom), 1'b0);
        cycle(1'b0, 1'b1, 8'h5A, 1'b1);
        chk("full_both_cnt", s_cnt, 15);
        chk("full_both_ovf", s_ovf, 1'b1);

        // Count 5, flush with winc
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        chk("pre_flush_cnt", s_cnt, 5);
        cycle(1'b1, 1'b1, 8'h77, 1'b0);
        chk("flush_cnt", s_cnt, 0);
        chk("flush_empty", s_rempty, 1'b1);
        chk("flush_aempty", s_ae, 1'b1);
        chk("flush_ovf", s_ovf, 1'b0);

        // Flush while full with both requests: no pulses
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, WIDTH'($urandom), 1'b0);
        cycle(1'b1, 1'b1, 8'h11, 1'b1);
        chk("flush_full_ovf", s_ovf, 1'b0);
        chk("flush_full_cnt", s_cnt, 0);

        // Asynchronous reset right after an overflow pulse
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, WIDTH'($urandom), 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 1'b1, 8'h33, 1'b0);
        cycle(1'b0, 1'b1, 8'h44, 1'b0);
        chk("pre_rst_ovf", s_ovf, 1'b1);
        #2 rstn = 1'b0;
        #1;
        model_reset();
        check_model();
        chk("rst_afull", s_af, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        winc = 1'b0; rinc = 1'b0; flush = 1'b0;
        @(negedge clk);
        check_model();

        // Randomised traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 31) == 0), ($urandom_range(0, 99) < 55), WIDTH'($urandom),
                  ($urandom_range(0, 99) < 50));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
